// File: rtl/q_measure.sv
// q_measure: measurement front-end between the ADC interface and the secant
// controller. After every i_ref change (or enable rising) it waits a fixed
// settling interval, then averages 2**LOG2_AVG ADC samples and publishes the
// mean, repeating continuously until i_ref changes again.
//
// Ports:
//   clk         clock
//   rst         asynchronous reset, active-high
//   enable      block active when high
//   i_ref       current reference from the controller, watched for changes
//   adc_data    unsigned ADC sample
//   adc_valid   adc_data valid this cycle (no backpressure)
//   q_measured  registered averaged measurement
//   ready       one-cycle strobe: q_measured is new
//   overrange   a sample in the published window was all-ones
//   busy        high while settling or accumulating
module q_measure #(
    parameter int unsigned BUS_WIDTH     = 10,
    parameter int unsigned ADC_WIDTH     = 10,
    parameter int unsigned LOG2_AVG      = 3,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_valid,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 overrange,
    output logic                 busy
);

    localparam int unsigned AW = ADC_WIDTH + LOG2_AVG;
    localparam int unsigned CW = LOG2_AVG + 1;
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_IDX    = CW'((1 << LOG2_AVG) - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        PUBLISH
    } state_t;

    state_t state, state_next;

    logic [BUS_WIDTH-1:0] i_ref_q;
    logic [SW-1:0]        settle_cnt;
    logic [AW-1:0]        acc;
    logic [CW-1:0]        cnt;
    logic                 sticky;

    logic                 change;
    logic                 sample_max;
    logic                 last_sample;
    logic [AW-1:0]        acc_sum;
    logic [ADC_WIDTH-1:0] mean;
    logic [BUS_WIDTH-1:0] mean_bus;
    logic                 unused_bits;

    logic settle_load;
    logic acc_clear;
    logic acc_take;
    logic publish;

    assign change      = enable && (i_ref != i_ref_q);
    assign sample_max  = &adc_data;
    assign last_sample = (cnt == LAST_IDX);
    // Sum includes the sample being accepted so the final one lands in the
    // published mean on the same edge it is taken.
    assign acc_sum     = acc + AW'(adc_data);
    assign mean        = acc_sum[AW-1:LOG2_AVG];

    generate
        if (ADC_WIDTH > BUS_WIDTH) begin : g_drop_lsbs
            assign mean_bus = mean[ADC_WIDTH-1 -: BUS_WIDTH];
        end else if (ADC_WIDTH < BUS_WIDTH) begin : g_pad_lsbs
            assign mean_bus = {mean, {(BUS_WIDTH - ADC_WIDTH){1'b0}}};
        end else begin : g_pass
            assign mean_bus = mean;
        end
    endgenerate

    // Low sum bits (and dropped mean bits) are intentionally discarded.
    assign unused_bits = ^{acc_sum, mean};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority: enable low, then i_ref change, then normal progress; a change
    // on the final-sample edge therefore drops the window without publishing.
    always_comb begin
        state_next  = state;
        settle_load = 1'b0;
        acc_clear   = 1'b0;
        acc_take    = 1'b0;
        publish     = 1'b0;
        ready       = (state == PUBLISH);
        busy        = (state == SETTLE) || (state == ACCUM);

        if (!enable) begin
            state_next = IDLE;
            acc_clear  = 1'b1;
        end else if (state == IDLE) begin
            state_next  = SETTLE;
            settle_load = 1'b1;
        end else if (change) begin
            state_next  = SETTLE;
            settle_load = 1'b1;
            acc_clear   = 1'b1;
        end else begin
            case (state)
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state_next = ACCUM;
                        acc_clear  = 1'b1;
                    end
                end
                ACCUM: begin
                    if (adc_valid) begin
                        acc_take = 1'b1;
                        if (last_sample) begin
                            publish    = 1'b1;
                            state_next = PUBLISH;
                        end
                    end
                end
                PUBLISH: begin
                    state_next = ACCUM;
                    acc_clear  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_ref_q    <= '0;
            settle_cnt <= '0;
            acc        <= '0;
            cnt        <= '0;
            sticky     <= 1'b0;
            q_measured <= '0;
            overrange  <= 1'b0;
        end else begin
            i_ref_q <= i_ref;

            if (settle_load) begin
                settle_cnt <= SETTLE_LOAD;
            end else if ((state == SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SW'(1);
            end

            if (acc_clear) begin
                acc    <= '0;
                cnt    <= '0;
                sticky <= 1'b0;
            end else if (acc_take) begin
                acc    <= acc_sum;
                cnt    <= cnt + CW'(1);
                sticky <= sticky | sample_max;
            end

            if (publish) begin
                q_measured <= mean_bus;
                overrange  <= sticky | sample_max;
            end
        end
    end

endmodule

// File: tb/tb_q_measure.sv
// Self-checking bench for q_measure (default parameters). Expected results
// are queued as each window is driven and compared when ready pulses.
module tb_q_measure;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       enable    = 1'b0;
    logic [9:0] i_ref     = '0;
    logic [9:0] adc_data  = '0;
    logic       adc_valid = 1'b0;
    logic [9:0] q_measured;
    logic       ready;
    logic       overrange;
    logic       busy;

    typedef struct {
        int q;
        int ovr;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   nchecks = 0;
    int   nerrors = 0;

    q_measure #(
        .BUS_WIDTH    (10),
        .ADC_WIDTH    (10),
        .LOG2_AVG     (3),
        .SETTLE_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .i_ref     (i_ref),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .q_measured(q_measured),
        .ready     (ready),
        .overrange (overrange),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Present one set of inputs for exactly one rising edge.
    task automatic tick(input logic v, input logic [9:0] d);
        adc_valid = v;
        adc_data  = d;
        @(posedge clk);
        #1;
    endtask

    // One steady-state window, called with the DUT in PUBLISH. Sample i is
    // base+i*step, optionally replaced at index 0 by 'first'. Ignored cycles
    // carry 1023 so any wrongly accepted sample corrupts the result.
    task automatic window(input int first, input int base, input int step,
                          input int q, input int ovr, input bit toggle);
        int start;
        int v;
        start = cyc;
        sb.push_back('{q, ovr, start + (toggle ? 16 : 9)});
        tick(!toggle, 10'h3FF);
        for (int i = 0; i < 8; i++) begin
            v = (first >= 0 && i == 0) ? first : base + i * step;
            tick(1'b1, 10'(v));
            if (toggle && i < 7) tick(1'b0, 10'h3FF);
        end
    endtask

    // Scoreboard consumer.
    initial begin
        exp_t e;
        logic ready_prev;
        ready_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ready_prev = 1'b0;
            end else begin
                if (ready) begin
                    check("ready_width", int'(ready_prev), 0);
                    if (sb.size() == 0) begin
                        check("spurious_ready", int'(ready), 0);
                    end else begin
                        e = sb.pop_front();
                        check("q_measured", int'(q_measured), e.q);
                        check("overrange", int'(overrange), e.ovr);
                        check("ready_cycle", cyc, e.cyc);
                    end
                end
                ready_prev = ready;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int start;

        // Reset state
        repeat (3) tick(1'b0, 10'd0);
        check("rst_q", int'(q_measured), 0);
        check("rst_ovr", int'(overrange), 0);
        check("rst_ready", int'(ready), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick(1'b0, 10'd0);
        check("idle_busy", int'(busy), 0);

        // Defaults: constant 100, first ready 24 cycles after enable sampled
        enable = 1'b1;
        i_ref  = 10'd0;
        start  = cyc;
        sb.push_back('{100, 0, start + 1 + 24});
        tick(1'b1, 10'd100);
        check("busy_after_enable", int'(busy), 1);
        repeat (24) tick(1'b1, 10'd100);
        window(-1, 100, 0, 100, 0, 1'b0);
        window(-1, 100, 0, 100, 0, 1'b0);

        // Ramp 0..7, a window with one 1023, then ramp again
        window(-1, 0, 1, 3, 0, 1'b0);
        window(1023, 0, 0, 127, 1, 1'b0);
        window(-1, 0, 1, 3, 0, 1'b0);

        // i_ref change after 5 accumulated samples
        tick(1'b1, 10'h3FF);
        repeat (5) tick(1'b1, 10'd100);
        i_ref = 10'd500;
        start = cyc;
        sb.push_back('{200, 0, start + 1 + 24});
        tick(1'b1, 10'd100);
        repeat (16) begin
            tick(1'b1, 10'h3FF);
            check("busy_resettle", int'(busy), 1);
        end
        repeat (8) tick(1'b1, 10'd200);

        // i_ref change on the same edge as the 8th sample
        tick(1'b1, 10'h3FF);
        repeat (7) tick(1'b1, 10'd100);
        i_ref = 10'd300;
        start = cyc;
        sb.push_back('{50, 0, start + 1 + 24});
        tick(1'b1, 10'd100);
        check("busy_change_last", int'(busy), 1);
        repeat (16) tick(1'b1, 10'h3FF);
        repeat (8) tick(1'b1, 10'd50);

        // adc_valid toggling: 16-cycle windows
        window(-1, 10, 10, 45, 0, 1'b1);
        window(1023, 1, 0, 128, 1, 1'b1);

        // enable dropped mid-ACCUM: outputs hold
        tick(1'b1, 10'h3FF);
        repeat (3) tick(1'b1, 10'd100);
        enable = 1'b0;
        tick(1'b1, 10'd100);
        check("dis_busy", int'(busy), 0);
        check("dis_ready", int'(ready), 0);
        check("dis_q", int'(q_measured), 128);
        check("dis_ovr", int'(overrange), 1);
        repeat (3) tick(1'b1, 10'h3FF);
        check("dis_q_hold", int'(q_measured), 128);

        // Asynchronous reset mid-SETTLE
        enable = 1'b1;
        tick(1'b0, 10'd0);
        repeat (4) tick(1'b1, 10'h3FF);
        check("settle_busy", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_q", int'(q_measured), 0);
        check("arst_ovr", int'(overrange), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_ready", int'(ready), 0);
        tick(1'b1, 10'd100);
        rst = 1'b0;

        // Recovery after reset
        start = cyc;
        sb.push_back('{100, 0, start + 1 + 24});
        tick(1'b1, 10'd100);
        repeat (24) tick(1'b1, 10'd100);
        enable = 1'b0;
        repeat (5) tick(1'b0, 10'd0);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule

// File: doc/q_measure.md
# q_measure

Measurement front-end that converts raw ADC samples of the plant output into the averaged `q_measured` word and one-cycle `ready` strobe consumed by the downstream secant controller. Whenever the controller changes `i_ref`, the block waits a fixed settling interval, then averages 2**LOG2_AVG ADC samples and publishes the mean. After that it keeps publishing fresh averages until `i_ref` changes again. It sits between the ADC interface and the control loop.

## Interface
- `BUS_WIDTH`, 10: width of `i_ref` and `q_measured`.
- `ADC_WIDTH`, 10: width of `adc_data`.
- `LOG2_AVG`, 3: log2 of the number of samples averaged per result. Range 0..6.
- `SETTLE_CYCLES`, 16: clk cycles spent in SETTLE after each `i_ref` change. Must be ≥ 1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  block active when high.
- `i_ref`  in  BUS_WIDTH  current reference from the controller. Monitored for changes.
- `adc_data`  in  ADC_WIDTH  unsigned ADC sample.
- `adc_valid`  in  1  `adc_data` is valid this cycle. No backpressure.
- `q_measured`  out  BUS_WIDTH  averaged measurement, registered.
- `ready`  out  1  one-cycle pulse: `q_measured` is new.
- `overrange`  out  1  at least one sample in the published window was all-ones. Updated together with `q_measured`.
- `busy`  out  1  high in SETTLE or ACCUM.

## Operation
- States: IDLE, SETTLE, ACCUM, PUBLISH.
- Reset: state IDLE, `q_measured`=0, `ready`=0, `overrange`=0, `busy`=0. Accumulator, sample counter, settle counter, `i_ref_q` and sticky overrange flag all cleared.
- `i_ref_q` registers `i_ref` every cycle. A change is defined as `i_ref != i_ref_q` while `enable`=1.
- IDLE → SETTLE when `enable`=1. The settle counter is loaded on entry.
- SETTLE:
  - `adc_valid` is ignored.
  - The state lasts exactly `SETTLE_CYCLES` cycles, then goes to ACCUM with the accumulator, sample count and sticky overrange cleared.
- ACCUM:
  - On each `adc_valid`: add `adc_data` to the accumulator and increment the count. Set the sticky overrange flag if `adc_data` is all-ones.
  - The accumulator is `ADC_WIDTH+LOG2_AVG` bits wide, so it cannot overflow.
  - When the 2**LOG2_AVG-th sample is accepted, go to PUBLISH. On that same edge, register `q_measured` and `overrange`.
- Mean: accumulator >> LOG2_AVG, then mapped to BUS_WIDTH.
  - If ADC_WIDTH > BUS_WIDTH, drop LSBs.
  - If ADC_WIDTH < BUS_WIDTH, zero-pad LSBs.
  - If the widths are equal, pass through unchanged.
- PUBLISH:
  - Lasts one cycle with `ready`=1. `adc_valid` is ignored.
  - Next state is ACCUM (continuous measurement) with the accumulator cleared.
- `i_ref` change in SETTLE, ACCUM or PUBLISH:
  - Next state is SETTLE, the settle counter reloads, and any partial accumulation is discarded.
  - A change takes priority over completion of the final sample: that window is dropped and no `ready` is issued.
- `enable`=0 in any state:
  - Next state is IDLE and the partial window is discarded.
  - `q_measured` and `overrange` hold their last values; `ready` and `busy` are 0.
- `ready` is combinationally `state==PUBLISH`. It is never high for two consecutive cycles.

## Timing
- Let E0 be the edge at which an `i_ref` change (or `enable` rising from IDLE) is detected. With `adc_valid` continuously high:
  - ACCUM is entered at E0+SETTLE_CYCLES.
  - The last sample is accepted at E0+SETTLE_CYCLES+2**LOG2_AVG.
  - `ready` is high in the following cycle, which is 24 cycles after E0 with defaults.
- In steady state the publish period is 2**LOG2_AVG+1 cycles when `adc_valid` is continuous: ACCUM samples plus one PUBLISH cycle.
- `q_measured` is stable from the `ready` cycle until the next PUBLISH entry.
- Asynchronous reset mid-window clears everything immediately. No `ready` is issued for that window.

## Test plan
- Reset, then `enable`=1, `i_ref`=0, `adc_data`=100 every cycle (defaults) → `ready` pulses 24 cycles after enable is sampled, with `q_measured`=100, `overrange`=0. Later pulses follow every 9 cycles.
- Samples 0,1,2,3,4,5,6,7 repeating → `q_measured`=3 (28>>3). A window containing one 1023 → `overrange`=1 for that result only.
- `i_ref` changes from 0 to 500 after 5 samples have been accumulated → no `ready` for that window. `busy` stays high and the next `ready` comes 24 cycles after the change.
- `i_ref` changes on the same edge as the 8th sample → no `ready` pulse; the block re-enters SETTLE.
- `adc_valid` toggling 1,0 → each window takes 16 cycles; `ready` is still a single cycle wide and values are correct.
- `enable` dropped mid-ACCUM → IDLE, `q_measured` holds its previous value. Separately, assert `rst` mid-SETTLE → all outputs are 0 asynchronously.
